unidad_division_secuencial: RTL and testbench

- Multi-cycle restoring divider. It is the inverse companion to the ALU multiply path and computes quotient and remainder one bit per clock.
- It sits beside the combinational ALU in the CPU datapath. The control unit launches it with a handshake and stalls until the result is valid.
- It reports status flags with the same four meanings as the ALU flags: negative, zero, overflow, carry.

---
 rtl/div_pkg.sv | 27 ++
 rtl/unidad_division_secuencial_paso.sv | 26 ++
 rtl/unidad_division_secuencial.sv | 188 ++++++++++++++++++
 tb/tb_unidad_division_secuencial.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// Shared types and constants for the sequential restoring divider.
// Optional signed mode is enabled with the SIGNED_DIV_EN macro (see unidad_division_secuencial).
package div_pkg;

    // Default operand width and the iteration counter width that goes with it
    localparam int DIV_N = 32;
    localparam int CNT_W = $clog2(DIV_N);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } estado_div_t;

    typedef struct packed {
        logic negativo;
        logic cero;
        logic desborde;
        logic acarreo;
    } banderas_t;

    // Counter width for an arbitrary operand width (counter must hold n-1)
    function automatic int ancho_cnt(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/unidad_division_secuencial_paso.sv
// One restoring-division iteration: shift in a dividend bit, trial-subtract
// the divisor, keep the difference when it does not borrow.
module paso_division #(
    parameter int N = 32
) (
    input  logic [N:0]   i_resto,
    input  logic [N-1:0] i_divisor,
    input  logic         i_bit,
    output logic [N:0]   o_resto,
    output logic         o_bit_q
);

    logic [N+1:0] w_desp;
    logic [N:0]   w_dif;
    logic         w_borrow;

    // Shifted partial remainder, trial difference and borrow detection
    always_comb begin
        w_desp   = {i_resto, i_bit};
        w_borrow = (w_desp < {2'b00, i_divisor});
        w_dif    = w_desp[N:0] - {1'b0, i_divisor};
        o_bit_q  = ~w_borrow;
        o_resto  = w_borrow ? w_desp[N:0] : w_dif;
    end

endmodule

// File: rtl/unidad_division_secuencial.sv
// Multi-cycle restoring divider, one quotient bit per clock.
// Handshake: a request (inicio) is taken only while listo=1 and A/B are
// captured on that edge; a result is presented while valido=1 and released
// by tomar on a clock edge. inicio outside IDLE and tomar outside DONE are
// ignored; tomar in DONE always wins over a simultaneous inicio.
// Define SIGNED_DIV_EN for two's complement operands (truncating division).
// o_estado exposes the FSM state for observation.
import div_pkg::*;

module unidad_division_secuencial #(
    parameter int N = DIV_N
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        inicio,
    input  logic [N-1:0] A,
    input  logic [N-1:0] B,
    output logic        listo,
    input  logic        tomar,
    output logic        valido,
    output logic [N-1:0] cociente,
    output logic [N-1:0] residuo,
    output logic        banNegativo,
    output logic        banCero,
    output logic        banDesborde,
    output logic        banAcarreo,
    output estado_div_t o_estado
);

    localparam int CW = (N == DIV_N) ? CNT_W : ancho_cnt(N);
    localparam logic [CW-1:0] CNT_INI = CW'(N - 1);

    estado_div_t   r_estado;
    logic [CW-1:0] r_cnt;
    logic          r_fin;       // all bits done: next CALC cycle publishes results
    logic          r_div_cero;
    logic [N:0]    r_resto;
    logic [N-1:0]  r_dividendo;
    logic [N-1:0]  r_divisor;
    logic [N-1:0]  r_coc_trab;
    logic [N-1:0]  r_cociente;
    logic [N-1:0]  r_residuo;
    banderas_t     r_ban;
    logic          r_listo;
    logic          r_valido;
`ifdef SIGNED_DIV_EN
    logic          r_neg_q;
    logic          r_neg_r;
    logic          r_desb_sig;
`endif

    logic [N:0]    w_resto_sig;
    logic          w_bit_q;
    logic [N-1:0]  w_a_mag;
    logic [N-1:0]  w_b_mag;
    logic [N-1:0]  w_coc_u;
    logic [N-1:0]  w_res_u;
    logic [N-1:0]  w_coc_fin;
    logic [N-1:0]  w_res_fin;
    banderas_t     w_ban_fin;

    paso_division #(.N(N)) u_paso (
        .i_resto   (r_resto),
        .i_divisor (r_divisor),
        .i_bit     (r_dividendo[N-1]),
        .o_resto   (w_resto_sig),
        .o_bit_q   (w_bit_q)
    );

`ifdef SIGNED_DIV_EN
    // Operand magnitudes; the unsigned core always works on these
    assign w_a_mag = A[N-1] ? ({N{1'b0}} - A) : A;
    assign w_b_mag = B[N-1] ? ({N{1'b0}} - B) : B;
`else
    assign w_a_mag = A;
    assign w_b_mag = B;
`endif

    // Final results and flags, published on the DONE entry edge
    always_comb begin
        w_coc_u = r_coc_trab;
        // On divide by zero no iteration ran, so the dividend register is still A
        w_res_u = r_div_cero ? r_dividendo : r_resto[N-1:0];
        w_ban_fin = '0;
`ifdef SIGNED_DIV_EN
        w_res_fin = r_neg_r ? ({N{1'b0}} - w_res_u) : w_res_u;
        w_coc_fin = r_div_cero ? {N{1'b1}}
                  : (r_neg_q ? ({N{1'b0}} - w_coc_u) : w_coc_u);
        w_ban_fin.negativo = w_coc_fin[N-1];
        w_ban_fin.desborde = r_div_cero | r_desb_sig;
`else
        w_res_fin = w_res_u;
        w_coc_fin = r_div_cero ? {N{1'b1}} : w_coc_u;
        w_ban_fin.negativo = 1'b0;
        w_ban_fin.desborde = r_div_cero;
`endif
        w_ban_fin.cero    = (w_coc_fin == '0);
        w_ban_fin.acarreo = (w_res_fin != '0);
    end

    // Control FSM with datapath registers and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_estado    <= IDLE;
            r_cnt       <= '0;
            r_fin       <= 1'b0;
            r_div_cero  <= 1'b0;
            r_resto     <= '0;
            r_dividendo <= '0;
            r_divisor   <= '0;
            r_coc_trab  <= '0;
            r_cociente  <= '0;
            r_residuo   <= '0;
            r_ban       <= '0;
            r_listo     <= 1'b1;
            r_valido    <= 1'b0;
`ifdef SIGNED_DIV_EN
            r_neg_q     <= 1'b0;
            r_neg_r     <= 1'b0;
            r_desb_sig  <= 1'b0;
`endif
        end else begin
            case (r_estado)
                IDLE: begin
                    if (inicio) begin
                        r_dividendo <= w_a_mag;
                        r_divisor   <= w_b_mag;
                        r_resto     <= '0;
                        r_coc_trab  <= '0;
                        r_cnt       <= CNT_INI;
                        // Divide by zero skips the iterations and publishes next edge
                        r_div_cero  <= (B == '0);
                        r_fin       <= (B == '0);
`ifdef SIGNED_DIV_EN
                        r_neg_q     <= A[N-1] ^ B[N-1];
                        r_neg_r     <= A[N-1];
                        r_desb_sig  <= (A == {1'b1, {(N-1){1'b0}}}) && (B == {N{1'b1}});
`endif
                        r_estado    <= CALC;
                        r_listo     <= 1'b0;
                    end
                end
                CALC: begin
                    if (r_fin) begin
                        r_cociente <= w_coc_fin;
                        r_residuo  <= w_res_fin;
                        r_ban      <= w_ban_fin;
                        r_fin      <= 1'b0;
                        r_estado   <= DONE;
                        r_valido   <= 1'b1;
                    end else begin
                        r_resto     <= w_resto_sig;
                        r_coc_trab  <= {r_coc_trab[N-2:0], w_bit_q};
                        r_dividendo <= {r_dividendo[N-2:0], 1'b0};
                        if (r_cnt == '0) begin
                            r_fin <= 1'b1;
                        end else begin
                            r_cnt <= r_cnt - CW'(1);
                        end
                    end
                end
                DONE: begin
                    if (tomar) begin
                        r_estado <= IDLE;
                        r_valido <= 1'b0;
                        r_listo  <= 1'b1;
                    end
                end
                default: begin
                    r_estado <= IDLE;
                    r_valido <= 1'b0;
                    r_listo  <= 1'b1;
                end
            endcase
        end
    end

    assign listo       = r_listo;
    assign valido      = r_valido;
    assign cociente    = r_cociente;
    assign residuo     = r_residuo;
    assign banNegativo = r_ban.negativo;
    assign banCero     = r_ban.cero;
    assign banDesborde = r_ban.desborde;
    assign banAcarreo  = r_ban.acarreo;
    assign o_estado    = r_estado;

endmodule

// File: tb/tb_unidad_division_secuencial.sv
// Bench for unidad_division_secuencial: directed handshake/reset cases plus
// random operands, checked by a scoreboard against an arithmetic model.
module tb_unidad_division_secuencial;
    import div_pkg::*;

    localparam int N = 32;
    localparam int W = 2 * N + 4;
    localparam logic [N-1:0] MIN_V = {1'b1, {(N-1){1'b0}}};

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        inicio = 1'b0;
    logic        tomar = 1'b0;
    logic [N-1:0] a_in = '0;
    logic [N-1:0] b_in = '0;
    logic        listo, valido;
    logic [N-1:0] cociente, residuo;
    logic        banNegativo, banCero, banDesborde, banAcarreo;
    estado_div_t estado;

    int checks = 0;
    int errors = 0;
    logic [W-1:0] exp_q[$];
    logic [W-1:0] sb_e;
    logic         val_prev = 1'b0;

    unidad_division_secuencial #(.N(N)) dut (
        .clk(clk), .rst_n(rst_n), .inicio(inicio), .A(a_in), .B(b_in),
        .listo(listo), .tomar(tomar), .valido(valido),
        .cociente(cociente), .residuo(residuo),
        .banNegativo(banNegativo), .banCero(banCero),
        .banDesborde(banDesborde), .banAcarreo(banAcarreo),
        .o_estado(estado)
    );

    // Clock and watchdog
    always #5 clk = ~clk;

    initial begin
        #3_000_000;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // Reference model: plain division arithmetic, packed {q, r, neg, zero, ovf, carry}
    function automatic logic [W-1:0] modelo(input logic [N-1:0] a, input logic [N-1:0] b);
        logic [N-1:0] q;
        logic [N-1:0] r;
        logic         neg;
        logic         desb;
`ifdef SIGNED_DIV_EN
        if (b == '0) begin
            q = '1; r = a; desb = 1'b1;
        end else if (a == MIN_V && b == '1) begin
            q = MIN_V; r = '0; desb = 1'b1;
        end else begin
            q = $signed(a) / $signed(b);
            r = $signed(a) % $signed(b);
            desb = 1'b0;
        end
        neg = q[N-1];
`else
        if (b == '0) begin
            q = '1; r = a; desb = 1'b1;
        end else begin
            q = a / b; r = a % b; desb = 1'b0;
        end
        neg = 1'b0;
`endif
        return {q, r, neg, (q == '0), desb, (r != '0)};
    endfunction

    task automatic chk(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard monitor: compares on each rising edge of valido
    always @(negedge clk) begin
        if (rst_n) begin
            if (valido && !val_prev) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL sb_unexpected result cociente=%0h with no request pending", cociente);
                end else begin
                    sb_e = exp_q.pop_front();
                    chk("sb_cociente", cociente, sb_e[W-1:N+4]);
                    chk("sb_residuo", residuo, sb_e[N+3:4]);
                    chk("sb_banNegativo", N'(banNegativo), N'(sb_e[3]));
                    chk("sb_banCero", N'(banCero), N'(sb_e[2]));
                    chk("sb_banDesborde", N'(banDesborde), N'(sb_e[1]));
                    chk("sb_banAcarreo", N'(banAcarreo), N'(sb_e[0]));
                end
            end
            val_prev = valido;
        end else begin
            val_prev = 1'b0;
        end
    end

    // Driver: wait for listo, present a request for one edge, queue its expectation
    task automatic start_div(input logic [N-1:0] a, input logic [N-1:0] b);
        int t = 0;
        @(negedge clk);
        while (!listo && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (!listo) begin
            checks++;
            errors++;
            $display("FAIL listo_timeout actual=0 required=1");
        end
        a_in = a;
        b_in = b;
        inicio = 1'b1;
        exp_q.push_back(modelo(a, b));
        @(posedge clk);
        #1;
        inicio = 1'b0;
        a_in = $urandom;
        b_in = $urandom;
    endtask

    // Count edges until valido and compare against the expected latency
    task automatic wait_valido(input int lat, input string name);
        int t = 0;
        while (!valido && t < 200) begin
            @(posedge clk);
            #1;
            t++;
        end
        checks++;
        if (t != lat) begin
            errors++;
            $display("FAIL %s_latency actual=%0d required=%0d", name, t, lat);
        end
        chk({name, "_listo_low"}, N'(listo), '0);
    endtask

    task automatic ack();
        repeat ($urandom_range(0, 2)) @(posedge clk);
        @(negedge clk);
        tomar = 1'b1;
        @(posedge clk);
        #1;
        tomar = 1'b0;
        chk("listo_after_tomar", N'(listo), N'(1));
        chk("valido_after_tomar", N'(valido), '0);
    endtask

    task automatic do_div(input logic [N-1:0] a, input logic [N-1:0] b);
        start_div(a, b);
        wait_valido((b == '0) ? 1 : N + 1, "div");
        ack();
    endtask

    task automatic chk_reset_outputs(input string name);
        chk({name, "_listo"}, N'(listo), N'(1));
        chk({name, "_valido"}, N'(valido), '0);
        chk({name, "_cociente"}, cociente, '0);
        chk({name, "_residuo"}, residuo, '0);
        chk({name, "_flags"}, N'({banNegativo, banCero, banDesborde, banAcarreo}), '0);
        chk({name, "_estado"}, N'(estado), N'(IDLE));
    endtask

    // Main stimulus sequence
    initial begin
        logic [N-1:0] ra;
        logic [N-1:0] rb;

        #12;
        chk_reset_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // 100 / 7 with absolute expectations
        start_div(32'd100, 32'd7);
        wait_valido(33, "d100_7");
        chk("d100_7_cociente", cociente, 32'd14);
        chk("d100_7_residuo", residuo, 32'd2);
        chk("d100_7_acarreo", N'(banAcarreo), N'(1));
        ack();

        do_div(32'd0, 32'd5);
        do_div(32'd9, 32'd0);

        // Request during CALC is ignored
        start_div(32'd1000, 32'd3);
        repeat (9) @(posedge clk);
        @(negedge clk);
        a_in = 32'd50;
        b_in = 32'd5;
        inicio = 1'b1;
        @(posedge clk);
        #1;
        inicio = 1'b0;
        wait_valido(23, "d1000_3");
        chk("d1000_3_cociente", cociente, 32'd333);
        chk("d1000_3_residuo", residuo, 32'd1);
        ack();
        repeat (3) @(posedge clk);
        #1;
        chk("no_queued_request", N'(valido), '0);

        // Asynchronous reset in the middle of a division
        start_div(32'd12345, 32'd67);
        repeat (4) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        exp_q.delete();
        #1;
        chk_reset_outputs("midreset");
        @(negedge clk);
        rst_n = 1'b1;
        do_div(32'd12345, 32'd67);

        // tomar and inicio together in DONE: only tomar acts
        start_div(32'd77, 32'd5);
        wait_valido(33, "b2b");
        @(negedge clk);
        tomar = 1'b1;
        inicio = 1'b1;
        a_in = 32'd3;
        b_in = 32'd1;
        @(posedge clk);
        #1;
        tomar = 1'b0;
        inicio = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("b2b_idle_listo", N'(listo), N'(1));
        chk("b2b_idle_estado", N'(estado), N'(IDLE));
        do_div(32'd3, 32'd1);

`ifdef SIGNED_DIV_EN
        start_div(-32'sd7, 32'd2);
        wait_valido(33, "s_m7_2");
        chk("s_m7_2_cociente", cociente, 32'hFFFF_FFFD);
        chk("s_m7_2_residuo", residuo, 32'hFFFF_FFFF);
        chk("s_m7_2_neg", N'(banNegativo), N'(1));
        ack();
        start_div(32'h8000_0000, 32'hFFFF_FFFF);
        wait_valido(33, "s_min_m1");
        chk("s_min_m1_cociente", cociente, 32'h8000_0000);
        chk("s_min_m1_residuo", residuo, '0);
        chk("s_min_m1_desb", N'(banDesborde), N'(1));
        ack();
        do_div(32'hFFFF_FFF0, 32'd0);
`endif

        // Random operands
        for (int i = 0; i < 1500; i++) begin
            ra = $urandom;
            case ($urandom_range(0, 9))
                0: rb = '0;
                1, 2, 3: rb = N'($urandom_range(1, 15));
                4: rb = ra;
                5: rb = ra >> $urandom_range(1, 31);
                6: rb = '1;
                default: rb = $urandom;
            endcase
            if ($urandom_range(0, 15) == 0) ra = MIN_V;
            if ($urandom_range(0, 15) == 0) ra = '0;
            do_div(ra, rb);
        end

        repeat (5) @(posedge clk);
        chk("sb_empty", N'(exp_q.size()), '0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
